// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin arbiter sharing one magnitude comparator; define CMP_SHARE_ARB_SIGNED_EN for signed compare
module cmp_share_arb #(
  parameter  int N   = 4,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_vld,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_rdy,
  output logic           rsp_vld,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_gt,
  output logic           rsp_lt,
  output logic           rsp_et,
  input  logic           rsp_rdy
);
  logic [IDW-1:0] ptr_q, ptr_d, win;
  logic           hit, open, xfer;
  logic [N-1:0]   a, b;
  logic           gt_d, lt_d;
  // round-robin search from ptr upward; smallest offset wins
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    hit = 1'b0;
    for (int k = R - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      j = (j >= R) ? j - R : j;
      if (req_vld[j]) begin
        win = IDW'(j);
        hit = 1'b1;
      end
    end
  end
  assign open    = !rsp_vld || rsp_rdy;
  assign req_rdy = (rst_n && open && hit) ? (R'(1) << win) : '0;
  assign xfer    = |req_rdy;
  assign a       = req_a[win*N +: N];
  assign b       = req_b[win*N +: N];
  assign ptr_d   = (win == IDW'(R - 1)) ? '0 : win + 1'b1;
`ifdef CMP_SHARE_ARB_SIGNED_EN
  assign gt_d = $signed(a) > $signed(b);
  assign lt_d = $signed(a) < $signed(b);
`else
  assign gt_d = a > b;
  assign lt_d = a < b;
`endif
  // result slot: load on transfer, empty on drain, hold under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_gt  <= 1'b0;
      rsp_lt  <= 1'b0;
      rsp_et  <= 1'b0;
    end else if (xfer) begin
      ptr_q   <= ptr_d;
      rsp_vld <= 1'b1;
      rsp_id  <= win;
      rsp_gt  <= gt_d;
      rsp_lt  <= lt_d;
      rsp_et  <= a == b;
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cmp_share_arb.sv
// tb_cmp_share_arb: directed self-checking bench for cmp_share_arb (N=4, R=4)
module tb_cmp_share_arb;
  logic        clk, rst_n, rsp_rdy;
  logic [3:0]  req_vld, req_rdy;
  logic [15:0] req_a, req_b;
  logic        rsp_vld, rsp_gt, rsp_lt, rsp_et;
  logic [1:0]  rsp_id;
  logic [2:0]  flags;
  int          checks = 0;
  int          failures = 0;
`ifdef CMP_SHARE_ARB_SIGNED_EN
  localparam logic [2:0] F_F1 = 3'b010;
  localparam logic [2:0] F_93 = 3'b010;
`else
  localparam logic [2:0] F_F1 = 3'b100;
  localparam logic [2:0] F_93 = 3'b100;
`endif
  logic [2:0] rr_f [4];
  assign flags = {rsp_gt, rsp_lt, rsp_et};
  cmp_share_arb #(.N(4), .R(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_gt(rsp_gt),
    .rsp_lt(rsp_lt), .rsp_et(rsp_et), .rsp_rdy(rsp_rdy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rr_f = '{3'b100, 3'b001, 3'b010, F_F1};
    rst_n = 1'b0; req_vld = 4'hF; rsp_rdy = 1'b1;
    req_a = 16'hF256; req_b = 16'h1753;
    repeat (3) begin
      tick;
      chk("rst_rdy", 32'(req_rdy), 0);
      chk("rst_vld", 32'(rsp_vld), 0);
      chk("rst_flags", 32'(flags), 0);
      chk("rst_id", 32'(rsp_id), 0);
    end
    rst_n = 1'b1;
    #1 chk("first_grant", 32'(req_rdy), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_vld", 32'(rsp_vld), 1);
      chk("rr_id", 32'(rsp_id), 32'(i % 4));
      chk("rr_flags", 32'(flags), 32'(rr_f[i % 4]));
      chk("rr_rdy", 32'(req_rdy), 32'(1) << ((i + 1) % 4));
    end
    rsp_rdy = 1'b0;
    #1 chk("bp_rdy0", 32'(req_rdy), 0);
    repeat (4) begin
      tick;
      chk("bp_vld", 32'(rsp_vld), 1);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_flags", 32'(flags), 32'b100);
      chk("bp_rdy", 32'(req_rdy), 0);
    end
    rsp_rdy = 1'b1;
    #1 chk("bp_resume", 32'(req_rdy), 32'b0010);
    tick;
    chk("bp_next_id", 32'(rsp_id), 1);
    chk("bp_next_flags", 32'(flags), 32'b001);
    req_vld = 4'b1000;
    #1 chk("mid_gnt", 32'(req_rdy), 32'b1000);
    tick;
    chk("mid_id", 32'(rsp_id), 3);
    chk("mid_flags", 32'(flags), 32'(F_F1));
    rsp_rdy = 1'b0; req_vld = 4'hF;
    #1 chk("mid_bp_rdy", 32'(req_rdy), 0);
    rst_n = 1'b0;
    #1 chk("mid_rst_rdy", 32'(req_rdy), 0);
    tick;
    chk("mid_rst_vld", 32'(rsp_vld), 0);
    chk("mid_rst_id", 32'(rsp_id), 0);
    chk("mid_rst_flags", 32'(flags), 0);
    rst_n = 1'b1; rsp_rdy = 1'b1;
    #1 chk("mid_first", 32'(req_rdy), 32'b0001);
    req_vld = 4'b0100; req_a = 16'h0900; req_b = 16'h0300;
    #1 chk("single_gnt", 32'(req_rdy), 32'b0100);
    tick;
    chk("single_vld", 32'(rsp_vld), 1);
    chk("single_id", 32'(rsp_id), 2);
    chk("single_93", 32'(flags), 32'(F_93));
    req_a = 16'h0500; req_b = 16'h0500;
    #1 chk("single_gnt2", 32'(req_rdy), 32'b0100);
    tick;
    chk("single_id2", 32'(rsp_id), 2);
    chk("single_55", 32'(flags), 32'b001);
    req_vld = 4'b0000;
    #1 chk("idle_rdy", 32'(req_rdy), 0);
    tick;
    chk("drain_vld", 32'(rsp_vld), 0);
    chk("drain_flags", 32'(flags), 32'b001);
    chk("drain_id", 32'(rsp_id), 2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; req_vld = 4'hF;
    #1 chk("ptr_reset", 32'(req_rdy), 32'b0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
